// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: serializes one load/store at a time and stalls the pipeline meanwhile.
// state | meaning  --  IDLE: waiting for a request | BUSY: counting wait states | DONE: result valid, pipeline released
module dmem_responder #(
    parameter int ADDR_BITS = 6,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 memreqM,
    input  logic                 memwriteM,
    input  logic [31:0]          addrM,
    input  logic [31:0]          writedataM,
    output logic [31:0]          readdataM,
    output logic                 stallM,
    output logic                 errM,
    input  logic [ADDR_BITS-1:0] dbg_addr,
    output logic [31:0]          dbg_data
);
    localparam int         WORDS = 2 ** ADDR_BITS;
    localparam logic [3:0] LAT   = 4'(LATENCY);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

    stateT                state;
    stateT                nextState;
    logic [3:0]           waitCnt;
    logic                 accept;
    logic                 finish;
    logic                 addrBad;
    logic                 reqWrite;
    logic                 reqBad;
    logic [ADDR_BITS-1:0] reqIndex;
    logic [31:0]          reqData;
    logic [31:0]          mem [WORDS];

    assign addrBad = (addrM[1:0] != 2'b00) || (addrM[31:ADDR_BITS+2] != '0);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        stallM    = 1'b0;
        accept    = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (memreqM) begin
                    stallM    = 1'b1;
                    accept    = 1'b1;
                    nextState = BUSY;
                end
            end
            BUSY: begin
                stallM = 1'b1;
                if (waitCnt == 4'd0) begin
                    finish    = 1'b1;
                    nextState = DONE;
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Request fields are captured only at acceptance; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            reqWrite <= memwriteM;
            reqBad   <= addrBad;
            reqIndex <= addrM[ADDR_BITS+1:2];
            reqData  <= writedataM;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            waitCnt   <= 4'd0;
            readdataM <= 32'd0;
            errM      <= 1'b0;
        end else begin
            errM <= 1'b0;
            if (accept) begin
                waitCnt <= LAT;
            end else if (state == BUSY && waitCnt != 4'd0) begin
                waitCnt <= waitCnt - 4'd1;
            end
            if (finish) begin
                if (reqBad) begin
                    readdataM <= 32'd0;
                    errM      <= 1'b1;
                end else if (!reqWrite) begin
                    readdataM <= mem[reqIndex];
                end
            end
        end
    end

    // Memory is never cleared; reset only blocks a commit on the same edge.
    always_ff @(posedge clk) begin
        if (!reset && finish && reqWrite && !reqBad) begin
            mem[reqIndex] <= reqData;
        end
    end

    assign dbg_data = mem[dbg_addr];
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY 2 and 0) checked against a word-array model.
module tb_dmem_responder;
    localparam int AB = 6;
    localparam int NW = 64;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] expRd;
        bit          expErr;
    } vecT;

    logic        clk = 1'b0;
    logic        reset      [2];
    logic        memreqM    [2];
    logic        memwriteM  [2];
    logic [31:0] addrM      [2];
    logic [31:0] writedataM [2];
    logic [31:0] readdataM  [2];
    logic        stallM     [2];
    logic        errM       [2];
    logic [AB-1:0] dbgAddr  [2];
    logic [31:0] dbgData    [2];

    int          lat [2];
    logic [31:0] model [2][NW];
    logic [31:0] lastRd [2];
    int          tests = 0;
    int          fails = 0;
    vecT         vec [10];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_BITS(AB), .LATENCY(2)) u0 (
        .clk(clk), .reset(reset[0]), .memreqM(memreqM[0]), .memwriteM(memwriteM[0]),
        .addrM(addrM[0]), .writedataM(writedataM[0]), .readdataM(readdataM[0]),
        .stallM(stallM[0]), .errM(errM[0]), .dbg_addr(dbgAddr[0]), .dbg_data(dbgData[0])
    );

    dmem_responder #(.ADDR_BITS(AB), .LATENCY(0)) u1 (
        .clk(clk), .reset(reset[1]), .memreqM(memreqM[1]), .memwriteM(memwriteM[1]),
        .addrM(addrM[1]), .writedataM(writedataM[1]), .readdataM(readdataM[1]),
        .stallM(stallM[1]), .errM(errM[1]), .dbg_addr(dbgAddr[1]), .dbg_data(dbgData[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic sync();
        @(negedge clk);
        #1;
    endtask

    // One complete access; expectations come from the word-array model and the stall rule LATENCY+2.
    task automatic doAccess(input int u, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                            input bit hold, output logic [31:0] rdOut, output logic errOut);
        int          stalls;
        bit          bad;
        logic [5:0]  idx;
        logic [31:0] expRd;
        stalls = 0;
        bad    = (addr[1:0] != 2'b00) || (addr[31:8] != 24'd0);
        idx    = addr[7:2];
        memreqM[u]    = 1'b1;
        memwriteM[u]  = wr;
        addrM[u]      = addr;
        writedataM[u] = wd;
        #1;
        while (stallM[u] === 1'b1 && stalls < 40) begin
            stalls++;
            check("rd_during_stall", readdataM[u], lastRd[u]);
            check("err_during_stall", 32'(errM[u]), 32'd0);
            @(negedge clk);
            if (!hold) begin
                memreqM[u]    = 1'b0;
                memwriteM[u]  = 1'($urandom_range(0, 1));
                addrM[u]      = $urandom;
                writedataM[u] = $urandom;
            end
            #1;
        end
        check("stall_cycles", 32'(stalls), 32'(lat[u] + 2));
        if (bad) begin
            expRd = 32'd0;
        end else if (wr) begin
            model[u][idx] = wd;
            expRd = lastRd[u];
        end else begin
            expRd = model[u][idx];
        end
        lastRd[u] = expRd;
        rdOut  = readdataM[u];
        errOut = errM[u];
        check("readdata", rdOut, expRd);
        check("err_pulse", 32'(errOut), 32'(bad));
        if (wr && !bad) begin
            dbgAddr[u] = idx;
            #1;
            check("dbg_after_store", dbgData[u], wd);
        end
        sync();
        check("err_cleared", 32'(errM[u]), 32'd0);
    endtask

    task automatic scanMem(input int u);
        for (int i = 0; i < NW; i++) begin
            dbgAddr[u] = i[5:0];
            #1;
            check("dbg_scan", dbgData[u], model[u][i]);
        end
        sync();
    endtask

    // Reset lands in the 2nd BUSY cycle (LATENCY=2) or on the would-be commit edge (LATENCY=0).
    task automatic resetMid(input int u, input logic [31:0] addr, input logic [31:0] wd);
        logic [5:0] idx;
        idx = addr[7:2];
        memreqM[u]    = 1'b1;
        memwriteM[u]  = 1'b1;
        addrM[u]      = addr;
        writedataM[u] = wd;
        sync();
        memreqM[u] = 1'b0;
        if (lat[u] >= 1) sync();
        check("stall_before_reset", 32'(stallM[u]), 32'd1);
        reset[u] = 1'b1;
        sync();
        reset[u] = 1'b0;
        lastRd[u] = 32'd0;
        dbgAddr[u] = idx;
        #1;
        check("reset_stall", 32'(stallM[u]), 32'd0);
        check("reset_rd", readdataM[u], 32'd0);
        check("reset_err", 32'(errM[u]), 32'd0);
        check("reset_no_commit", dbgData[u], model[u][idx]);
        sync();
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        lat[0] = 2;
        lat[1] = 0;
        vec[0] = '{0, 32'h0000_0000, 32'h0,         32'hC0DE_0000, 0};
        vec[1] = '{1, 32'h0000_0014, 32'hDEADBEEF,  32'hC0DE_0000, 0};
        vec[2] = '{0, 32'h0000_0014, 32'h0,         32'hDEADBEEF,  0};
        vec[3] = '{0, 32'h0000_0013, 32'h0,         32'h0,         1};
        vec[4] = '{0, 32'h0000_0100, 32'h0,         32'h0,         1};
        vec[5] = '{0, 32'h0000_00FC, 32'h0,         32'hC0DE_003F, 0};
        vec[6] = '{1, 32'h0000_00FC, 32'h12345678,  32'hC0DE_003F, 0};
        vec[7] = '{1, 32'h0000_0102, 32'h55AA55AA,  32'h0,         1};
        vec[8] = '{0, 32'h0000_00FC, 32'h0,         32'h12345678,  0};
        vec[9] = '{0, 32'h0000_0008, 32'h0,         32'hC0DE_0002, 0};

        for (int u = 0; u < 2; u++) begin
            reset[u]      = 1'b1;
            memreqM[u]    = 1'b0;
            memwriteM[u]  = 1'b0;
            addrM[u]      = 32'd0;
            writedataM[u] = 32'd0;
            dbgAddr[u]    = '0;
            lastRd[u]     = 32'd0;
        end
        repeat (3) @(negedge clk);
        reset[0] = 1'b0;
        reset[1] = 1'b0;
        #1;
        for (int u = 0; u < 2; u++) begin
            check("init_rd", readdataM[u], 32'd0);
            check("init_err", 32'(errM[u]), 32'd0);
            check("init_stall", 32'(stallM[u]), 32'd0);
        end

        for (int u = 0; u < 2; u++)
            for (int i = 0; i < NW; i++)
                doAccess(u, 1'b1, 32'(i) << 2, {16'hC0DE, 16'(i)}, 1'b0, rd, er);

        for (int k = 0; k < 10; k++) begin
            doAccess(0, vec[k].wr, vec[k].addr, vec[k].wd, 1'b0, rd, er);
            check("vec_rd", rd, vec[k].expRd);
            check("vec_err", 32'(er), 32'(vec[k].expErr));
        end
        scanMem(0);

        doAccess(0, 1'b1, 32'h20, 32'hCAFEF00D, 1'b1, rd, er);
        doAccess(0, 1'b0, 32'h20, 32'h0, 1'b0, rd, er);
        check("b2b_load", rd, 32'hCAFEF00D);

        resetMid(0, 32'h8, 32'h0BADF00D);
        doAccess(0, 1'b0, 32'h8, 32'h0, 1'b0, rd, er);
        check("after_reset_load", rd, 32'hC0DE_0002);
        resetMid(1, 32'h8, 32'h0BADF00D);

        for (int u = 0; u < 2; u++) begin
            for (int k = 0; k < 150; k++) begin
                int          r;
                bit          hold;
                logic [31:0] a;
                r = $urandom_range(0, 9);
                if (r == 0)      a = $urandom;
                else if (r == 1) a = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
                else             a = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
                hold = ($urandom_range(0, 3) == 0) && (k < 149);
                doAccess(u, 1'($urandom_range(0, 1)), a, $urandom, hold, rd, er);
                if (!hold) repeat ($urandom_range(0, 2)) sync();
            end
            memreqM[u] = 1'b0;
            sync();
            scanMem(u);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
